// File: rtl/comp_pkg.sv
// Shared compression-path definitions: word/count widths, packer state
// encoding, and the code-length clamp used by both compressor and packer.
package comp_pkg;

    localparam int WORD_W = 64;
    localparam int CNT_W  = 8;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        LAST  = 2'd2
    } packer_state_t;

    // Code lengths above one word are treated as a full word.
    function automatic logic [6:0] clamp_len(input logic [CNT_W-1:0] bits);
        if (bits > CNT_W'(64)) begin
            return 7'd64;
        end else begin
            return bits[6:0];
        end
    endfunction

    // Mask with the low n bits set (n = 0..64).
    function automatic logic [WORD_W-1:0] low_mask(input logic [6:0] n);
        if (n >= 7'd64) begin
            return {WORD_W{1'b1}};
        end else begin
            return ~({WORD_W{1'b1}} << n);
        end
    endfunction

endpackage

// File: rtl/packer_out_reg.sv
// Single-entry valid/ready holding register for packed output words.
// The fields stay frozen while a word waits for the downstream stage.
module packer_out_reg
    import comp_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic [WORD_W-1:0] load_data,
    input  logic [6:0]        load_bits,
    input  logic              load_last,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_data,
    output logic [6:0]        out_bits,
    output logic              out_last
);

    logic              valid_r;
    logic [WORD_W-1:0] data_r;
    logic [6:0]        bits_r;
    logic              last_r;

    // Capture a new word when loaded, drop valid on handshake, otherwise hold.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_r <= 1'b0;
            data_r  <= {WORD_W{1'b0}};
            bits_r  <= 7'd0;
            last_r  <= 1'b0;
        end else if (load) begin
            valid_r <= 1'b1;
            data_r  <= load_data;
            bits_r  <= load_bits;
            last_r  <= load_last;
        end else if (out_ready) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign out_valid = valid_r;
    assign out_data  = data_r;
    assign out_bits  = bits_r;
    assign out_last  = last_r;

endmodule

// File: rtl/huffman_bit_packer.sv
// Packs right-aligned variable-length Huffman codes LSB-first into 64-bit
// words. A flush drains full words and then emits a zero-padded last word
// tagged out_last. Optional statistics counters are enabled by defining
// PACKER_STATS_EN; without it stat_bits/stat_words read as zero.
module huffman_bit_packer
    import comp_pkg::*;
#(
    parameter int STAT_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_code,
    input  logic [CNT_W-1:0]  in_bits,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic [6:0]        out_bits,
    output logic              out_last,
    output logic [STAT_W-1:0] stat_bits,
    output logic [STAT_W-1:0] stat_words
);

    logic [2*WORD_W-1:0] acc_r;
    logic [7:0]          fill_r;
    packer_state_t       state_r;

    logic [6:0]          n_s;
    logic [WORD_W-1:0]   code_s;
    logic                in_ready_s;
    logic                accept_s;
    logic                free_s;
    logic                emit_full_s;
    logic                emit_last_s;
    logic                load_s;
    logic [WORD_W-1:0]   load_data_s;
    logic [6:0]          load_bits_s;
    logic                load_last_s;
    logic [2*WORD_W-1:0] acc_base_s;
    logic [7:0]          fill_base_s;
    logic [2*WORD_W-1:0] acc_next_s;
    logic [7:0]          fill_next_s;

    assign n_s         = clamp_len(in_bits);
    assign code_s      = in_code & low_mask(n_s);
    // Holding at most 64 bits before accepting keeps fill within 128.
    assign in_ready_s  = (state_r == RUN) && (fill_r <= 8'd64);
    assign accept_s    = in_valid && in_ready_s;
    assign free_s      = !out_valid || out_ready;
    assign emit_full_s = free_s && (fill_r >= 8'd64) && (state_r != LAST);
    assign emit_last_s = free_s && (state_r == LAST);
    assign load_s      = emit_full_s || emit_last_s;
    assign in_ready    = in_ready_s;

    // Select the word handed to the output register: full word or padded tail.
    always_comb begin
        load_data_s = {WORD_W{1'b0}};
        load_bits_s = 7'd0;
        load_last_s = 1'b0;
        if (emit_full_s) begin
            load_data_s = acc_r[WORD_W-1:0];
            load_bits_s = 7'd64;
            load_last_s = 1'b0;
        end else if (emit_last_s) begin
            load_data_s = acc_r[WORD_W-1:0] & low_mask(fill_r[6:0]);
            load_bits_s = fill_r[6:0];
            load_last_s = 1'b1;
        end else begin
            load_data_s = {WORD_W{1'b0}};
            load_bits_s = 7'd0;
            load_last_s = 1'b0;
        end
    end

    // Next accumulator: retire an emitted word first, then merge an accepted code above the remaining fill.
    always_comb begin
        acc_base_s  = acc_r;
        fill_base_s = fill_r;
        acc_next_s  = acc_r;
        fill_next_s = fill_r;
        if (emit_full_s) begin
            acc_base_s  = {{WORD_W{1'b0}}, acc_r[2*WORD_W-1:WORD_W]};
            fill_base_s = fill_r - 8'd64;
        end else begin
            acc_base_s  = acc_r;
            fill_base_s = fill_r;
        end
        if (emit_last_s) begin
            acc_next_s  = {(2*WORD_W){1'b0}};
            fill_next_s = 8'd0;
        end else if (accept_s) begin
            acc_next_s  = acc_base_s | ({{WORD_W{1'b0}}, code_s} << fill_base_s);
            fill_next_s = fill_base_s + {1'b0, n_s};
        end else begin
            acc_next_s  = acc_base_s;
            fill_next_s = fill_base_s;
        end
    end

    // Accumulator, fill level and RUN/FLUSH/LAST sequencing.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_r   <= {(2*WORD_W){1'b0}};
            fill_r  <= 8'd0;
            state_r <= RUN;
        end else begin
            acc_r  <= acc_next_s;
            fill_r <= fill_next_s;
            case (state_r)
                RUN: begin
                    if (flush) begin
                        state_r <= FLUSH;
                    end else begin
                        state_r <= RUN;
                    end
                end
                FLUSH: begin
                    if (fill_r < 8'd64) begin
                        state_r <= LAST;
                    end else begin
                        state_r <= FLUSH;
                    end
                end
                LAST: begin
                    if (free_s) begin
                        state_r <= RUN;
                    end else begin
                        state_r <= LAST;
                    end
                end
                default: begin
                    state_r <= RUN;
                end
            endcase
        end
    end

    packer_out_reg u_out_reg (
        .clock     (clock),
        .reset     (reset),
        .load      (load_s),
        .load_data (load_data_s),
        .load_bits (load_bits_s),
        .load_last (load_last_s),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_bits  (out_bits),
        .out_last  (out_last)
    );

`ifdef PACKER_STATS_EN
    logic [STAT_W-1:0] stat_bits_r;
    logic [STAT_W-1:0] stat_words_r;

    // Free-running wrap-around counters of accepted bits and delivered words.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stat_bits_r  <= {STAT_W{1'b0}};
            stat_words_r <= {STAT_W{1'b0}};
        end else begin
            if (accept_s) begin
                stat_bits_r <= stat_bits_r + STAT_W'(n_s);
            end else begin
                stat_bits_r <= stat_bits_r;
            end
            if (out_valid && out_ready) begin
                stat_words_r <= stat_words_r + {{(STAT_W-1){1'b0}}, 1'b1};
            end else begin
                stat_words_r <= stat_words_r;
            end
        end
    end

    assign stat_bits  = stat_bits_r;
    assign stat_words = stat_words_r;
`else
    assign stat_bits  = {STAT_W{1'b0}};
    assign stat_words = {STAT_W{1'b0}};
`endif

endmodule

// File: tb/tb_huffman_bit_packer.sv
// Directed bench for huffman_bit_packer: packing, backpressure, flush,
// length clamp/masking and mid-stream reset, with hand-computed words.
module tb_huffman_bit_packer;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_code;
    logic [7:0]  in_bits;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [6:0]  out_bits;
    logic        out_last;
    logic [31:0] stat_bits;
    logic [31:0] stat_words;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [63:0] q_data[$];
    logic [6:0]  q_bits[$];
    logic        q_last[$];

    huffman_bit_packer #(.STAT_W(32)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_code    (in_code),
        .in_bits    (in_bits),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_bits   (out_bits),
        .out_last   (out_last),
        .stat_bits  (stat_bits),
        .stat_words (stat_words)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Record every word that will complete a handshake at the next rising edge.
    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            q_data.push_back(out_data);
            q_bits.push_back(out_bits);
            q_last.push_back(out_last);
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_q();
        q_data.delete();
        q_bits.delete();
        q_last.delete();
    endtask

    // Present one beat and hold it until accepted (bounded).
    task automatic send(input logic [63:0] c, input logic [7:0] b);
        bit ok;
        ok       = 1'b0;
        in_code  = c;
        in_bits  = b;
        in_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clock);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("send_timeout", 128'(0), 128'(1));
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(posedge clock);
        #1;
        flush = 1'b0;
    endtask

    task automatic wait_q(input int n, input string tag);
        for (int k = 0; k < 50; k++) begin
            if (q_data.size() >= n) break;
            @(posedge clock);
            #2;
        end
        check(tag, 128'(q_data.size()), 128'(n));
    endtask

    task automatic expect_word(input int i, input logic [63:0] d, input logic [6:0] b,
                               input logic l, input string tag);
        check({tag, "_data"}, 128'(q_data[i]), 128'(d));
        check({tag, "_bits"}, 128'(q_bits[i]), 128'(b));
        check({tag, "_last"}, 128'(q_last[i]), 128'(l));
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_code   = 64'd0;
        in_bits   = 8'd0;
        flush     = 1'b0;
        out_ready = 1'b1;
        clear_q();
        #1;
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_out_data",  128'(out_data),  128'(0));
        check("rst_out_bits",  128'(out_bits),  128'(0));
        check("rst_out_last",  128'(out_last),  128'(0));
        check("rst_in_ready",  128'(in_ready),  128'(1));
        check("rst_stat_bits", 128'(stat_bits), 128'(0));
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;

        // 1: eight byte beats form one word
        for (int i = 1; i <= 8; i++) send(64'(i), 8'd8);
        check("t1_not_yet", 128'(out_valid), 128'(0));
        @(posedge clock);
        #1;
        check("t1_valid", 128'(out_valid), 128'(1));
        check("t1_data", 128'(out_data), 128'(64'h0807060504030201));
        check("t1_bits", 128'(out_bits), 128'(64));
        wait_q(1, "t1_count");
        clear_q();

        // 2: word spanning two beats, then flush of the 4-bit remainder
        send(64'h0FFF_FFFF_FFFF_FFFF, 8'd60);
        send(64'h0000_0000_0000_00A5, 8'd8);
        pulse_flush();
        wait_q(2, "t2_count");
        expect_word(0, 64'h5FFF_FFFF_FFFF_FFFF, 7'd64, 1'b0, "t2_w0");
        expect_word(1, 64'h0000_0000_0000_000A, 7'd4, 1'b1, "t2_w1");
        clear_q();

        // 3: backpressure with 130 bits offered
        out_ready = 1'b0;
        send(64'h1122_3344_5566_7788, 8'd64);
        send(64'hCAFE_F00D_DEAD_BEEF, 8'd64);
        send(64'h0000_0000_0000_0002, 8'd2);
        check("t3_in_ready_low", 128'(in_ready), 128'(0));
        check("t3_valid_held", 128'(out_valid), 128'(1));
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check("t3_data_stable", 128'(out_data), 128'(64'h1122_3344_5566_7788));
        end
        @(posedge clock);
        #1;
        out_ready = 1'b1;
        wait_q(2, "t3_drain");
        pulse_flush();
        wait_q(3, "t3_count");
        expect_word(0, 64'h1122_3344_5566_7788, 7'd64, 1'b0, "t3_w0");
        expect_word(1, 64'hCAFE_F00D_DEAD_BEEF, 7'd64, 1'b0, "t3_w1");
        expect_word(2, 64'h0000_0000_0000_0002, 7'd2, 1'b1, "t3_w2");
        clear_q();

        // 4: empty flush gives a zero end marker; flush with a coincident beat includes it
        pulse_flush();
        wait_q(1, "t4a_count");
        expect_word(0, 64'd0, 7'd0, 1'b1, "t4a");
        clear_q();
        in_code  = 64'h0000_0000_0000_BEEF;
        in_bits  = 8'd16;
        in_valid = 1'b1;
        pulse_flush();
        in_valid = 1'b0;
        wait_q(1, "t4b_count");
        expect_word(0, 64'h0000_0000_0000_BEEF, 7'd16, 1'b1, "t4b");
        clear_q();

        // 5: over-long length clamps to 64, upper garbage is masked
        send(64'hFFFF_FFFF_FFFF_FFFF, 8'd200);
        send(64'h0000_0000_0000_FFFD, 8'd3);
        pulse_flush();
        wait_q(2, "t5_count");
        expect_word(0, 64'hFFFF_FFFF_FFFF_FFFF, 7'd64, 1'b0, "t5_w0");
        expect_word(1, 64'h0000_0000_0000_0005, 7'd3, 1'b1, "t5_w1");
        clear_q();

        // 6: reset with buffered bits and a pending word
        out_ready = 1'b0;
        send(64'h1122_3344_5566_7788, 8'd64);
        send(64'h0000_0012_3456_789A, 8'd40);
        check("t6_pending", 128'(out_valid), 128'(1));
`ifdef PACKER_STATS_EN
        check("t6_stat_bits_pre",  128'(stat_bits),  128'(449));
        check("t6_stat_words_pre", 128'(stat_words), 128'(10));
`else
        check("t6_stat_bits_off",  128'(stat_bits),  128'(0));
        check("t6_stat_words_off", 128'(stat_words), 128'(0));
`endif
        #2;
        reset = 1'b1;
        #1;
        check("t6_valid_cleared", 128'(out_valid),  128'(0));
        check("t6_data_cleared",  128'(out_data),   128'(0));
        check("t6_bits_cleared",  128'(out_bits),   128'(0));
        check("t6_stat_bits",     128'(stat_bits),  128'(0));
        check("t6_stat_words",    128'(stat_words), 128'(0));
        @(posedge clock);
        #1;
        reset     = 1'b0;
        out_ready = 1'b1;
        clear_q();
        @(posedge clock);
        #1;
        check("t6_in_ready", 128'(in_ready), 128'(1));
        pulse_flush();
        wait_q(1, "t6_count");
        expect_word(0, 64'd0, 7'd0, 1'b1, "t6_empty");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
